// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore FSM that runs the CPU datapath for one instruction per start/waiting
// handshake. It covers arithmetic/move operations, memory load/store over a
// ready-based memory handshake, HALT, and illegal-opcode detection.
//
// Optional feature (compile-time macro MEM_TIMEOUT_EN):
//   defined   - a RD/WR state that waits TIMEOUT_CYC cycles without mem_ready
//               gives up. The FSM returns to WAIT and sets err.
//   undefined - no timeout counter; RD/WR wait for mem_ready indefinitely.
//
// Parameters:
//   TIMEOUT_CYC  memory stall limit in cycles (1..255, used with MEM_TIMEOUT_EN)
//   CNT_W        stall counter width, derived from TIMEOUT_CYC
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             execute the instruction on opcode/op (taken in WAIT only)
//   opcode, op        instruction class / sub-operation
//   mem_ready         memory finished the current read/write this cycle
//   waiting           idle, ready for start
//   halted            HALT executed (only rst_n leaves it)
//   err               illegal opcode / memory timeout, sticky until next start
//   reg_sel           register-file index mux: 00 Rm, 01 Rd, 10 Rn
//   wb_sel            writeback mux: 00 C, 10 sximm8, 11 mem_rdata
//   w_en              register-file write
//   en_A/en_B/en_C    pipeline register loads
//   en_status         status register load
//   sel_A, sel_B      ALU source mux (sel_A=1 zero, sel_B=1 sximm5)
//   load_addr         load memory address register from C
//   mem_cmd           00 none, 01 read, 10 write
//
// State table:
//   state  | meaning
//   WAIT   | idle, accepting start
//   MOVI   | write sximm8 into Rn
//   GET_B  | read Rm into B
//   GET_A  | read Rn into A
//   ALU    | compute into C
//   STAT   | load status flags (CMP)
//   WB     | write C into Rd
//   ADDR   | C = A + sximm5 (effective address)
//   LADDR  | load memory address register
//   RD     | memory read, held until mem_ready
//   LWB    | write mem_rdata into Rd
//   GET_D  | read Rd into B (store data)
//   MOVD   | C = 0 + B (store data to C)
//   WR     | memory write, held until mem_ready
//   HALT   | terminal, only rst_n exits
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic       mem_ready,
  output logic       waiting,
  output logic       halted,
  output logic       err,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       load_addr,
  output logic [1:0] mem_cmd
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255 || CNT_W != $clog2(TIMEOUT_CYC + 1)) begin : g_param_check
    $error("multicycle_controller: TIMEOUT_CYC must be 1..255 and CNT_W must not be overridden");
  end

  localparam logic [4:0] I_MOVI = 5'b11010;
  localparam logic [4:0] I_MOV  = 5'b11000;
  localparam logic [4:0] I_ADD  = 5'b10100;
  localparam logic [4:0] I_CMP  = 5'b10101;
  localparam logic [4:0] I_AND  = 5'b10110;
  localparam logic [4:0] I_MVN  = 5'b10111;
  localparam logic [4:0] I_LDR  = 5'b01100;
  localparam logic [4:0] I_STR  = 5'b10000;
  localparam logic [4:0] I_HALT = 5'b11100;

  typedef enum logic [3:0] {
    S_WAIT, S_MOVI, S_GET_B, S_GET_A, S_ALU, S_STAT, S_WB, S_ADDR,
    S_LADDR, S_RD, S_LWB, S_GET_D, S_MOVD, S_WR, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] ins_q, ins_d;
  logic       err_q, err_d;
  logic [4:0] ins_in;

  assign ins_in = {opcode, op};

  // First state of each legal instruction; S_WAIT marks an illegal code.
  function automatic state_t first_state(input logic [4:0] ins);
    case (ins)
      I_MOVI:                      first_state = S_MOVI;
      I_MOV, I_ADD, I_CMP,
      I_AND, I_MVN:                first_state = S_GET_B;
      I_LDR, I_STR:                first_state = S_GET_A;
      I_HALT:                      first_state = S_HALT;
      default:                     first_state = S_WAIT;
    endcase
  endfunction

`ifdef MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ins_q   <= 5'b00000;
      err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
      err_q   <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    err_d   = err_q;
`ifdef MEM_TIMEOUT_EN
    // Cleared everywhere outside RD/WR, so it is zero on entry to either.
    cnt_d   = '0;
`endif
    case (state_q)
      S_WAIT: begin
        if (start) begin
          if (first_state(ins_in) == S_WAIT) begin
            err_d = 1'b1;
          end else begin
            ins_d   = ins_in;
            err_d   = 1'b0;
            state_d = first_state(ins_in);
          end
        end
      end
      S_MOVI:  state_d = S_WAIT;
      S_GET_B: state_d = (ins_q == I_MOV || ins_q == I_MVN) ? S_ALU : S_GET_A;
      S_GET_A: begin
        if (ins_q == I_LDR || ins_q == I_STR) state_d = S_ADDR;
        else if (ins_q == I_CMP)              state_d = S_STAT;
        else                                  state_d = S_ALU;
      end
      S_ALU:   state_d = S_WB;
      S_STAT:  state_d = S_WAIT;
      S_WB:    state_d = S_WAIT;
      S_ADDR:  state_d = S_LADDR;
      S_LADDR: state_d = (ins_q == I_LDR) ? S_RD : S_GET_D;
      S_LWB:   state_d = S_WAIT;
      S_GET_D: state_d = S_MOVD;
      S_MOVD:  state_d = S_WR;
      S_RD, S_WR: begin
        // mem_ready on the expiry cycle still counts as normal completion.
        if (mem_ready) begin
          state_d = (state_q == S_RD) ? S_LWB : S_WAIT;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = S_WAIT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_WAIT;
    endcase
  end

  assign err = err_q;

  always_comb begin
    waiting   = 1'b0;
    halted    = 1'b0;
    reg_sel   = 2'b00;
    wb_sel    = 2'b00;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = 2'b00;
    case (state_q)
      S_WAIT:  waiting = 1'b1;
      S_MOVI: begin
        reg_sel = 2'b10;
        wb_sel  = 2'b10;
        w_en    = 1'b1;
      end
      S_GET_B: en_B = 1'b1;
      S_GET_A: begin
        reg_sel = 2'b10;
        en_A    = 1'b1;
      end
      S_ALU: begin
        en_C  = 1'b1;
        // MOV passes B through by adding it to zero.
        sel_A = (ins_q == I_MOV);
      end
      S_STAT:  en_status = 1'b1;
      S_WB: begin
        reg_sel = 2'b01;
        w_en    = 1'b1;
      end
      S_ADDR: begin
        sel_B = 1'b1;
        en_C  = 1'b1;
      end
      S_LADDR: load_addr = 1'b1;
      S_RD:    mem_cmd   = 2'b01;
      S_LWB: begin
        reg_sel = 2'b01;
        wb_sel  = 2'b11;
        w_en    = 1'b1;
      end
      S_GET_D: begin
        reg_sel = 2'b01;
        en_B    = 1'b1;
      end
      S_MOVD: begin
        sel_A = 1'b1;
        en_C  = 1'b1;
      end
      S_WR:    mem_cmd = 2'b10;
      S_HALT:  halted  = 1'b1;
      default: waiting = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Runs directed and random instruction streams. A reference model builds the
// per-cycle control word from the instruction step lists and the memory
// latency drawn for each instruction. Every cycle's outputs are compared at
// the falling clock edge. Build with +define+MEM_TIMEOUT_EN to use the
// timeout variant (TIMEOUT_CYC=4).
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

`ifdef MEM_TIMEOUT_EN
  localparam int TCYC  = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TCYC  = 16;
  localparam bit TO_EN = 1'b0;
`endif

  localparam int K_WAIT = 0,  K_MOVI = 1,  K_GET_B = 2,  K_GET_A = 3,  K_ALU  = 4;
  localparam int K_STAT = 5,  K_WB   = 6,  K_ADDR  = 7,  K_LADDR = 8,  K_RD   = 9;
  localparam int K_LWB  = 10, K_GET_D = 11, K_MOVD = 12, K_WR    = 13, K_HALT = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic       mem_ready = 1'b0;
  logic       waiting, halted, err, w_en, en_A, en_B, en_C, en_status;
  logic       sel_A, sel_B, load_addr;
  logic [1:0] reg_sel, wb_sel, mem_cmd;

  int   checks = 0;
  int   failures = 0;
  logic err_m = 1'b0;
  int   seq[$];

  logic [4:0] legal_ins [9] = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110,
                                5'b10111, 5'b01100, 5'b10000, 5'b11100};

  multicycle_controller #(.TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .op(op),
    .mem_ready(mem_ready), .waiting(waiting), .halted(halted), .err(err),
    .reg_sel(reg_sel), .wb_sel(wb_sel), .w_en(w_en), .en_A(en_A), .en_B(en_B),
    .en_C(en_C), .en_status(en_status), .sel_A(sel_A), .sel_B(sel_B),
    .load_addr(load_addr), .mem_cmd(mem_cmd)
  );

  always #5 clk = ~clk;

  wire [16:0] obs = {waiting, halted, err, reg_sel, wb_sel, w_en, en_A, en_B,
                     en_C, en_status, sel_A, sel_B, load_addr, mem_cmd};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%05h exp=%05h", tag, $time, got, exp);
    end
  endtask

  // Expected control word for one step of an instruction.
  function automatic logic [16:0] word(input int k, input bit mov, input logic e);
    logic [16:0] r;
    r = '0;
    r[14] = e;
    case (k)
      K_WAIT:  r[16] = 1'b1;
      K_MOVI:  begin r[13:12] = 2'b10; r[11:10] = 2'b10; r[9] = 1'b1; end
      K_GET_B: r[7] = 1'b1;
      K_GET_A: begin r[13:12] = 2'b10; r[8] = 1'b1; end
      K_ALU:   begin r[6] = 1'b1; r[4] = mov; end
      K_STAT:  r[5] = 1'b1;
      K_WB:    begin r[13:12] = 2'b01; r[9] = 1'b1; end
      K_ADDR:  begin r[6] = 1'b1; r[3] = 1'b1; end
      K_LADDR: r[2] = 1'b1;
      K_RD:    r[1:0] = 2'b01;
      K_LWB:   begin r[13:12] = 2'b01; r[11:10] = 2'b11; r[9] = 1'b1; end
      K_GET_D: begin r[13:12] = 2'b01; r[7] = 1'b1; end
      K_MOVD:  begin r[6] = 1'b1; r[4] = 1'b1; end
      K_WR:    r[1:0] = 2'b10;
      K_HALT:  r[15] = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic bit build_seq(input logic [4:0] ins);
    seq.delete();
    case (ins)
      5'b11010: seq = '{K_MOVI};
      5'b11000: seq = '{K_GET_B, K_ALU, K_WB};
      5'b10100: seq = '{K_GET_B, K_GET_A, K_ALU, K_WB};
      5'b10110: seq = '{K_GET_B, K_GET_A, K_ALU, K_WB};
      5'b10101: seq = '{K_GET_B, K_GET_A, K_STAT};
      5'b10111: seq = '{K_GET_B, K_ALU, K_WB};
      5'b01100: seq = '{K_GET_A, K_ADDR, K_LADDR, K_RD, K_LWB};
      5'b10000: seq = '{K_GET_A, K_ADDR, K_LADDR, K_GET_D, K_MOVD, K_WR};
      5'b11100: seq = '{K_HALT};
      default:  return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'($urandom);
    mem_ready = 1'($urandom);
    @(negedge clk);
    check_val("reset", obs, word(K_WAIT, 1'b0, 1'b0));
    err_m = 1'b0;
    rst_n = 1'b1;
    start = 1'b0;
    mem_ready = 1'b0;
  endtask

  // lat: stall cycles before mem_ready; rst_at: memory cycle index to reset in (-1 none).
  task automatic run_instr(input logic [4:0] ins, input int lat, input int rst_at);
    bit legal, mov, done;
    check_val("idle", obs, word(K_WAIT, 1'b0, err_m));
    legal = build_seq(ins);
    mov = (ins == 5'b11000);
    {opcode, op} = ins;
    start = 1'b1;
    mem_ready = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    if (!legal) begin
      err_m = 1'b1;
      return;
    end
    err_m = 1'b0;
    done = 1'b0;
    foreach (seq[i]) begin
      if (done) break;
      if (seq[i] == K_HALT) begin
        for (int h = 0; h < 4; h++) begin
          start = 1'b1;
          {opcode, op} = legal_ins[$urandom_range(0, 8)];
          check_val("halt", obs, word(K_HALT, 1'b0, 1'b0));
          @(negedge clk);
        end
        do_reset();
        done = 1'b1;
      end else if (seq[i] == K_RD || seq[i] == K_WR) begin
        for (int c = 0; c <= lat; c++) begin
          start = 1'($urandom);
          {opcode, op} = 5'($urandom);
          if (seq[i] == K_RD) check_val("rd", obs, word(K_RD, mov, 1'b0));
          else                check_val("wr", obs, word(K_WR, mov, 1'b0));
          if (c == rst_at) begin
            do_reset();
            done = 1'b1;
            break;
          end
          mem_ready = (c == lat);
          @(negedge clk);
          if (TO_EN && c + 1 == TCYC && c != lat) begin
            err_m = 1'b1;
            done = 1'b1;
            break;
          end
        end
        mem_ready = 1'b0;
      end else begin
        start = 1'($urandom);
        {opcode, op} = 5'($urandom);
        mem_ready = 1'($urandom);
        check_val("step", obs, word(seq[i], mov, 1'b0));
        @(negedge clk);
      end
    end
    start = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, rat;
    logic [4:0] ins;
    do_reset();
    run_instr(5'b11010, 0, -1);   // MOVI
    run_instr(5'b10100, 0, -1);   // ADD
    run_instr(5'b10101, 0, -1);   // CMP
    run_instr(5'b01100, 3, -1);   // LDR, ready after 3 stalls
    run_instr(5'b10000, 0, -1);   // STR, ready at once
    run_instr(5'b00100, 0, -1);   // illegal -> err
    run_instr(5'b00100, 0, -1);   // illegal again, err stays
    run_instr(5'b11000, 0, -1);   // MOV clears err
    run_instr(5'b01100, 20, -1);  // long stall (times out when enabled)
    run_instr(5'b10111, 0, -1);   // MVN
    run_instr(5'b01100, TCYC - 1, -1); // ready exactly on the expiry cycle
    run_instr(5'b10000, TCYC, -1);
    run_instr(5'b01100, 5, 2);    // reset during RD
    run_instr(5'b11100, 0, -1);   // HALT, then reset
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 7) ins = legal_ins[$urandom_range(0, 8)];
      else                          ins = 5'($urandom);
      lat = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 6);
      rat = ($urandom_range(0, 14) == 0) ? $urandom_range(0, lat) : -1;
      run_instr(ins, lat, rat);
    end
    check_val("final_idle", obs, word(K_WAIT, 1'b0, err_m));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
